bf16_mult_arbiter: RTL and testbench
====================================

BF16_MULT_ARBITER -- requirements
Module: bf16_mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters sharing one multiplier_bf16 (2..8).
REQ-002 SHALL have these ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_a  in  16*N  bf16 operand A; slice i = bits [16i+15:16i].
- req_b  in  16*N  bf16 operand B, same slicing.
- req_STB  in  N  per-requester input strobe.
- req_BUSY  out  N  per-requester busy; 0 = arbiter accepts that requester.
- res_data  out  16  bf16 product delivered to the granted requester.
- res_id  out  3  index of the requester owning res_data.
- res_STB  out  N  per-requester result strobe.
- res_BUSY  in  N  per-requester result-sink busy.
- mult_a, mult_b  out  16  operands to multiplier_bf16.
- mult_input_STB  out  1  multiplier input strobe.
- mult_BUSY  in  1  multiplier input busy.
- mult_result  in  16  multiplier product.
- mult_output_STB  in  1  multiplier result strobe.
- mult_output_module_BUSY  out  1  arbiter busy toward the multiplier result.
- ops_done  out  16  count of completed deliveries.

Function
REQ-003 SHALL define a transfer on any channel as a rising edge where STB=1 and BUSY=0.
REQ-004 SHALL register all outputs; no combinational input-to-output path.
REQ-005 SHALL run a state machine with states ARB, CAPTURE, ISSUE, WAIT, DELIVER.
REQ-006 ARB behaviour:
- req_BUSY = all ones.
- If any req_STB is set, grant the first asserted index searching from (last_grant+1) mod N upward with wrap.
- Latch the grant index, clear req_BUSY[grant], go to CAPTURE.
- If no req_STB is set, stay in ARB.
REQ-007 CAPTURE behaviour:
- On transfer of requester g: latch req_a/req_b slice g into mult_a/mult_b, set req_BUSY[g]=1, set mult_input_STB=1, go to ISSUE.
- If req_STB[g]=0 in CAPTURE: set req_BUSY[g]=1, return to ARB, leave last_grant unchanged.
REQ-008 ISSUE: on mult_input_STB=1 and mult_BUSY=0, clear mult_input_STB, clear mult_output_module_BUSY, go to WAIT.
REQ-009 WAIT behaviour:
- On mult_output_STB=1 and mult_output_module_BUSY=0: latch res_data=mult_result and res_id=g.
- In the same edge: set mult_output_module_BUSY=1, set res_STB[g]=1, go to DELIVER.
REQ-010 DELIVER behaviour:
- On res_STB[g]=1 and res_BUSY[g]=0: clear res_STB[g], set last_grant=g, increment ops_done (wraps 0xFFFF to 0x0000), go to ARB.
REQ-011 SHALL assert at most one bit of res_STB at a time, and at most one bit of req_BUSY low at a time.
REQ-012 SHALL have exactly one operation in flight; new requests are held (req_BUSY=1) until DELIVER completes.
REQ-013 SHALL ignore req_STB changes of non-granted requesters outside ARB, and SHALL NOT modify operands or product.
REQ-014 Minimum latency, request-visible to res_STB set, with a zero-wait multiplier: 4 cycles plus multiplier latency.
REQ-015 A requester re-asserting immediately after delivery SHALL lose to any other pending requester (round-robin fairness).

Reset
REQ-016 On rst=0 at a rising edge, regardless of state, the block SHALL set:
- state=ARB
- req_BUSY=all ones, res_STB=0, mult_input_STB=0, mult_output_module_BUSY=1
- res_data=0, res_id=0, mult_a=0, mult_b=0
- ops_done=0, last_grant=N-1, so requester 0 wins first.
REQ-017 Reset asserted mid-operation SHALL abandon the operation without delivering a result; the multiplier is reset by the same rst.

Verification
REQ-018 Single request: req 0 presents a=0x4000, b=0x4040 -> res_STB[0]=1, res_data=0x40C0, res_id=0, ops_done=1.
REQ-019 All four requesters strobe together with operands 0x3FC0×0x3FC0 -> grants in order 0,1,2,3; each receives 0x4010; ops_done=4.
REQ-020 Requester 2 holds res_BUSY[2]=1 for 10 cycles -> res_STB[2] and res_data stay stable, req_BUSY stays all ones, then delivery completes on release.
REQ-021 Requester 1 drops req_STB in CAPTURE -> return to ARB with no multiplier strobe; requester 3 pending is granted next.
REQ-022 rst=0 asserted during WAIT -> next cycle shows all reset values; no res_STB pulse; a fresh request then completes normally.
REQ-023 ops_done preloaded via 65535 deliveries (or forced) -> the next delivery wraps it to 0x0000.

Source files
------------

// File: rtl/bf16_mult_arbiter.sv
// bf16_mult_arbiter: round-robin front end that shares one bf16 multiplier
// among N requesters, with a single operation in flight at a time.
`timescale 1ns/1ps
module bf16_mult_arbiter #(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [16*N-1:0] req_a,
    input  logic [16*N-1:0] req_b,
    input  logic [N-1:0]    req_STB,
    output logic [N-1:0]    req_BUSY,
    output logic [15:0]     res_data,
    output logic [2:0]      res_id,
    output logic [N-1:0]    res_STB,
    input  logic [N-1:0]    res_BUSY,
    output logic [15:0]     mult_a,
    output logic [15:0]     mult_b,
    output logic            mult_input_STB,
    input  logic            mult_BUSY,
    input  logic [15:0]     mult_result,
    input  logic            mult_output_STB,
    output logic            mult_output_module_BUSY,
    output logic [15:0]     ops_done
);

    typedef enum logic [2:0] {
        ARB,
        CAPTURE,
        ISSUE,
        WAIT,
        DELIVER
    } state_t;

    state_t       state_q;
    logic [2:0]   grant_q;
    logic [2:0]   last_q;
    logic [N-1:0] gnt_oh_q;
    logic [N-1:0] req_busy_q;
    logic [N-1:0] res_stb_q;
    logic [15:0]  res_data_q;
    logic [2:0]   res_id_q;
    logic [15:0]  mult_a_q;
    logic [15:0]  mult_b_q;
    logic         mult_stb_q;
    logic         mult_obusy_q;
    logic [15:0]  ops_done_q;

    logic [2:0]   grant_d;
    logic [N-1:0] gnt_oh_d;
    logic [2:0]   pick_hi;
    logic [2:0]   pick_lo;
    logic         hit_hi;
    logic [15:0]  op_a;
    logic [15:0]  op_b;
    logic         gnt_stb;
    logic         gnt_sink_busy;

    // Lowest requester above last_q wins; otherwise wrap to the lowest overall.
    always_comb begin
        pick_hi = '0;
        pick_lo = '0;
        hit_hi  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_STB[i]) begin
                pick_lo = 3'(i);
                if (3'(i) > last_q) begin
                    pick_hi = 3'(i);
                    hit_hi  = 1'b1;
                end
            end
        end
        grant_d = hit_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        gnt_oh_d = '0;
        for (int i = 0; i < N; i++) begin
            gnt_oh_d[i] = (3'(i) == grant_d);
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_oh_q[i]) begin
                op_a = req_a[16*i +: 16];
                op_b = req_b[16*i +: 16];
            end
        end
    end

    assign gnt_stb       = |(req_STB & gnt_oh_q);
    assign gnt_sink_busy = |(res_BUSY & gnt_oh_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_q       <= 3'(N - 1);
            gnt_oh_q     <= '0;
            req_busy_q   <= '1;
            res_stb_q    <= '0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_stb_q   <= 1'b0;
            mult_obusy_q <= 1'b1;
            ops_done_q   <= '0;
        end else begin
            unique case (state_q)
                ARB: begin
                    if (|req_STB) begin
                        grant_q    <= grant_d;
                        gnt_oh_q   <= gnt_oh_d;
                        req_busy_q <= ~gnt_oh_d;
                        state_q    <= CAPTURE;
                    end else begin
                        req_busy_q <= '1;
                    end
                end
                CAPTURE: begin
                    req_busy_q <= '1;
                    if (gnt_stb) begin
                        mult_a_q   <= op_a;
                        mult_b_q   <= op_b;
                        mult_stb_q <= 1'b1;
                        state_q    <= ISSUE;
                    end else begin
                        // Requester withdrew; last_q keeps its old value.
                        state_q <= ARB;
                    end
                end
                ISSUE: begin
                    if (!mult_BUSY) begin
                        mult_stb_q   <= 1'b0;
                        mult_obusy_q <= 1'b0;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mult_output_STB) begin
                        res_data_q   <= mult_result;
                        res_id_q     <= grant_q;
                        mult_obusy_q <= 1'b1;
                        res_stb_q    <= gnt_oh_q;
                        state_q      <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (!gnt_sink_busy) begin
                        res_stb_q  <= '0;
                        last_q     <= grant_q;
                        ops_done_q <= ops_done_q + 16'd1;
                        state_q    <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign req_BUSY                = req_busy_q;
    assign res_STB                 = res_stb_q;
    assign res_data                = res_data_q;
    assign res_id                  = res_id_q;
    assign mult_a                  = mult_a_q;
    assign mult_b                  = mult_b_q;
    assign mult_input_STB          = mult_stb_q;
    assign mult_output_module_BUSY = mult_obusy_q;
    assign ops_done                = ops_done_q;

endmodule

// File: tb/tb_bf16_mult_arbiter.sv
// tb_bf16_mult_arbiter: scoreboard bench with a behavioural bf16 multiplier
// stub, directed scenarios and a randomized multi-requester phase.
`timescale 1ns/1ps
module tb_bf16_mult_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [N-1:0]    req_STB;
    logic [N-1:0]    req_BUSY;
    logic [15:0]     res_data;
    logic [2:0]      res_id;
    logic [N-1:0]    res_STB;
    logic [N-1:0]    res_BUSY;
    logic [15:0]     mult_a;
    logic [15:0]     mult_b;
    logic            mult_input_STB;
    logic            mult_BUSY;
    logic [15:0]     mult_result;
    logic            mult_output_STB;
    logic            mult_output_module_BUSY;
    logic [15:0]     ops_done;

    logic [15:0] ra [N];
    logic [15:0] rb [N];
    logic [N-1:0] rs;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int          dlog[$];
    int          exp_ord[$];
    logic [15:0] exp_ops = '0;
    int          checks = 0;
    int          errors = 0;
    int          drv_active = 0;
    int          n_issue = 0;
    bit          stub_rand = 1'b0;
    int          stub_lat = 0;
    bit          rand_sink = 1'b0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[16*g +: 16] = ra[g];
        assign req_b[16*g +: 16] = rb[g];
    end
    assign req_STB = rs;

    bf16_mult_arbiter #(.N(N)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_a                   (req_a),
        .req_b                   (req_b),
        .req_STB                 (req_STB),
        .req_BUSY                (req_BUSY),
        .res_data                (res_data),
        .res_id                  (res_id),
        .res_STB                 (res_STB),
        .res_BUSY                (res_BUSY),
        .mult_a                  (mult_a),
        .mult_b                  (mult_b),
        .mult_input_STB          (mult_input_STB),
        .mult_BUSY               (mult_BUSY),
        .mult_result             (mult_result),
        .mult_output_STB         (mult_output_STB),
        .mult_output_module_BUSY (mult_output_module_BUSY),
        .ops_done                (ops_done)
    );

    always #5 clk = ~clk;

    // Normal-range bf16 product, round to nearest even.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [8:0]  mant;
        logic [7:0]  rem;
        logic [7:0]  half;
        int          e;
        p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            mant = {1'b0, p[15:8]};
            rem  = p[7:0];
            half = 8'h80;
            e++;
        end else begin
            mant = {1'b0, p[14:7]};
            rem  = {1'b0, p[6:0]};
            half = 8'h40;
        end
        if (rem > half || (rem == half && mant[0])) mant++;
        if (mant[8]) begin
            mant = mant >> 1;
            e++;
        end
        return {a[15] ^ b[15], 8'(e), mant[6:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)),
                7'($urandom_range(0, 127))};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Delivery order when every masked requester is pending at once.
    function automatic void rr_expect(input logic [N-1:0] pend, input int last);
        exp_ord.delete();
        while (pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (pend[c]) begin
                    exp_ord.push_back(c);
                    pend[c] = 1'b0;
                    last = c;
                    break;
                end
            end
        end
    endfunction

    function automatic void chk_order(input string name);
        chk({name, "_count"}, dlog.size(), exp_ord.size());
        for (int j = 0; j < exp_ord.size() && j < dlog.size(); j++)
            chk(name, dlog[j], exp_ord[j]);
    endfunction

    initial begin : mult_stub
        int phase;
        int cnt;
        logic [15:0] pa;
        logic [15:0] pb;
        phase = 0;
        cnt = 0;
        pa = '0;
        pb = '0;
        mult_BUSY = 1'b0;
        mult_output_STB = 1'b0;
        mult_result = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase = 0;
            end else if (phase == 0 && mult_input_STB && !mult_BUSY) begin
                pa = mult_a;
                pb = mult_b;
                n_issue++;
                cnt = stub_rand ? int'($urandom_range(0, 3)) : stub_lat;
                phase = 1;
            end else if (phase == 2 && mult_output_STB && !mult_output_module_BUSY) begin
                phase = 0;
            end
            @(posedge clk);
            #1;
            if (phase == 1) begin
                if (cnt == 0) begin
                    mult_result = bf16_mul(pa, pb);
                    mult_output_STB = 1'b1;
                    phase = 2;
                end else begin
                    cnt--;
                end
            end
            if (phase == 0) begin
                mult_output_STB = 1'b0;
                mult_BUSY = stub_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end else begin
                mult_BUSY = 1'b1;
            end
        end
    end

    initial begin : sink_noise
        forever begin
            @(posedge clk);
            #1;
            if (rand_sink)
                for (int i = 0; i < N; i++) res_BUSY[i] = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin : monitor
        int k;
        int j;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("req_BUSY_one_low", $countones(~req_BUSY) <= 1, 1);
                chk("res_STB_one_high", $countones(res_STB) <= 1, 1);
                if (|(res_STB & ~res_BUSY)) begin
                    k = -1;
                    for (int i = 0; i < N; i++) if (res_STB[i]) k = i;
                    chk("res_id", res_id, k);
                    j = -1;
                    for (int m = 0; m < sb.size(); m++)
                        if (j < 0 && int'(sb[m].id) == k) j = m;
                    if (j < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_delivery: got id %0d expected none", k);
                    end else begin
                        chk("res_data", res_data, sb[j].val);
                        sb.delete(j);
                    end
                    chk("ops_done_at_delivery", ops_done, exp_ops);
                    exp_ops++;
                    dlog.push_back(k);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_reset(input string tag);
        chk({tag, "_req_BUSY"}, req_BUSY, {N{1'b1}});
        chk({tag, "_res_STB"}, res_STB, 0);
        chk({tag, "_mult_input_STB"}, mult_input_STB, 0);
        chk({tag, "_mult_obusy"}, mult_output_module_BUSY, 1);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_mult_a"}, mult_a, 0);
        chk({tag, "_mult_b"}, mult_b, 0);
        chk({tag, "_ops_done"}, ops_done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;
        sb.delete();
        dlog.delete();
        exp_ops = '0;
    endtask

    task automatic do_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bit got;
        exp_t e;
        ra[i] = a;
        rb[i] = b;
        rs[i] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge clk);
            got = rs[i] && !req_BUSY[i];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_accept_%0d: got busy expected accept", i);
            rs[i] = 1'b0;
            return;
        end
        e.id = 3'(i);
        e.val = bf16_mul(a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        rs[i] = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while ((drv_active != 0 || sb.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= budget) begin
            errors++;
            $display("FAIL %s_idle: got pending %0d expected 0", name, sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic multi_req(input logic [N-1:0] mask, input logic [15:0] a,
                             input logic [15:0] b);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                drv_active++;
                fork
                    automatic int k = i;
                    begin
                        do_req(k, a, b);
                        drv_active--;
                    end
                join_none
            end
        end
        wait_idle("multi", 2000);
    endtask

    task automatic rand_driver(input int k, input int n);
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk);
                #1;
            end
            do_req(k, rand_op(), rand_op());
        end
    endtask

    task automatic random_phase(input int n);
        rand_sink = 1'b1;
        stub_rand = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_active++;
            fork
                automatic int k = i;
                begin
                    rand_driver(k, n);
                    drv_active--;
                end
            join_none
        end
        wait_idle("random", 20000);
        rand_sink = 1'b0;
        stub_rand = 1'b0;
        res_BUSY = '0;
    endtask

    initial begin : main
        bit got;
        int n0;
        logic [15:0] hold_exp;
        rs = '0;
        res_BUSY = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        do_req(0, 16'h4000, 16'h4040);
        wait_idle("single", 200);
        chk("single_res_data", res_data, 16'h40C0);
        chk("single_res_id", res_id, 0);
        chk("single_ops_done", ops_done, 1);

        dlog.delete();
        multi_req(4'b0101, 16'h3F80, 16'h3F80);
        rr_expect(4'b0101, 0);
        chk_order("fairness_order");

        do_reset();
        multi_req(4'b1111, 16'h3FC0, 16'h3FC0);
        rr_expect(4'b1111, N - 1);
        chk_order("all4_order");
        chk("all4_res_data", res_data, 16'h4010);
        chk("all4_ops_done", ops_done, 4);

        dlog.delete();
        n0 = n_issue;
        ra[1] = 16'h4000;
        rb[1] = 16'h4000;
        ra[3] = 16'h4040;
        rb[3] = 16'h3F80;
        rs[1] = 1'b1;
        rs[3] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk);
            #1;
            got = !req_BUSY[1];
        end
        chk("drop_grant1", got, 1);
        rs[1] = 1'b0;
        do_req(3, 16'h4040, 16'h3F80);
        wait_idle("drop", 200);
        chk("drop_issue_count", n_issue - n0, 1);
        rr_expect(4'b1000, 3);
        chk_order("drop_order");
        chk("drop_res_data", res_data, 16'h4040);

        res_BUSY = 4'b0100;
        do_req(2, 16'h4080, 16'h4000);
        hold_exp = bf16_mul(16'h4080, 16'h4000);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = res_STB[2];
        end
        chk("hold_res_STB_seen", got, 1);
        for (int h = 0; h < 10; h++) begin
            chk("hold_res_STB", res_STB, 4'b0100);
            chk("hold_res_data", res_data, hold_exp);
            chk("hold_req_BUSY", req_BUSY, {N{1'b1}});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_BUSY = '0;
        wait_idle("hold", 200);
        chk("hold_ops_done", ops_done, 6);

        stub_lat = 6;
        do_req(0, 16'h4000, 16'h4000);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clk);
            #1;
            got = !mult_output_module_BUSY;
        end
        chk("midrst_in_wait", got, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midrst");
        rst = 1'b1;
        sb.delete();
        dlog.delete();
        exp_ops = '0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("midrst_no_res_STB", res_STB, 0);
        end
        stub_lat = 0;
        @(posedge clk);
        #1;
        do_req(1, 16'h3FC0, 16'h4000);
        wait_idle("midrst_fresh", 200);
        chk("midrst_fresh_ops_done", ops_done, 1);
        chk("midrst_fresh_res_data", res_data, 16'h4040);

        do_reset();
        force dut.ops_done_q = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        release dut.ops_done_q;
        @(negedge clk);
        chk("wrap_preload", ops_done, 16'hFFFF);
        exp_ops = 16'hFFFF;
        @(posedge clk);
        #1;
        do_req(2, 16'h3F80, 16'h4000);
        wait_idle("wrap", 200);
        chk("wrap_ops_done", ops_done, 16'h0000);

        do_reset();
        random_phase(10);
        chk("random_ops_done", ops_done, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
